// File: rtl/perf_counter_bank_pkg.sv
// Shared definitions for the performance-counter bank.
// Latency: n/a (constants and helpers only).
// Backpressure: n/a.
package perf_counter_bank_pkg;

    // Counter overflow behaviour (SatMode parameter encodings).
    localparam int MODE_WRAP = 0;  // all-ones + 1 -> 0
    localparam int MODE_SAT  = 1;  // all-ones + 1 -> all-ones

    // Readout source select (rd_src encodings).
    localparam logic RD_SRC_LIVE   = 1'b0;
    localparam logic RD_SRC_SHADOW = 1'b1;

    // Channel-select width: clog2 of the channel count, never narrower than one bit.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/perf_counter_cell.sv
// One event counter with a snapshot shadow register and a sticky overflow flag.
// Latency: count, shadow and flag update on the rising clk edge after the strobe.
// Backpressure: none; every qualified strobe is counted, no stall path exists.
//
// Ports: clk, rst_n (async active-low); en (global enable); inc (event strobe);
//        clr (sync clear of count + flag); snap (copy count into shadow);
//        cnt (live count); shadow (snapshot); ovf (sticky overflow).
module perf_counter_cell
    import perf_counter_bank_pkg::*;
#(
    parameter int CntBit  = 32,
    parameter int SatMode = MODE_WRAP
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              inc,
    input  logic              clr,
    input  logic              snap,
    output logic [CntBit-1:0] cnt,
    output logic [CntBit-1:0] shadow,
    output logic              ovf
);

    logic bump;
    logic at_max;

    assign bump   = en && inc && !clr;
    assign at_max = &cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            shadow <= '0;
            ovf    <= 1'b0;
        end else begin
            // The shadow takes the pre-update value, so a snap coinciding with
            // an increment or a clear still captures the old count.
            if (snap) begin
                shadow <= cnt;
            end

            if (clr) begin
                cnt <= '0;
                ovf <= 1'b0;
            end else if (bump) begin
                if (at_max) begin
                    ovf <= 1'b1;
                    cnt <= (SatMode == MODE_SAT) ? cnt : '0;
                end else begin
                    cnt <= cnt + CntBit'(1);
                end
            end
        end
    end

endmodule

// File: rtl/perf_counter_bank.sv
// Bank of NumCh event counters with snapshot shadows and a registered readout port.
// Latency: rd_data reflects the selected source as of the previous clk edge (1 cycle).
// Backpressure: none; inputs are sampled every cycle, readout is always valid.
//
// Ports: clk, rst_n (async active-low); en (global count enable);
//        inc[NumCh] (per-channel event strobes); clr (sync clear of counts + ovf);
//        snap (copy all live counts to shadows); rd_src (0 live / 1 shadow);
//        sel (readout channel; out-of-range reads 0); rd_data (registered readout);
//        ovf[NumCh] (sticky overflow flags, straight from flops).
module perf_counter_bank
    import perf_counter_bank_pkg::*;
#(
    parameter int  NumCh   = 8,
    parameter int  CntBit  = 32,
    parameter int  SatMode = MODE_WRAP,
    localparam int SelW    = sel_width(NumCh)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [NumCh-1:0]  inc,
    input  logic              clr,
    input  logic              snap,
    input  logic              rd_src,
    input  logic [SelW-1:0]   sel,
    output logic [CntBit-1:0] rd_data,
    output logic [NumCh-1:0]  ovf
);

    logic [CntBit-1:0] live   [NumCh];
    logic [CntBit-1:0] shadow [NumCh];
    logic [CntBit-1:0] rd_next;

    for (genvar i = 0; i < NumCh; i++) begin : g_cell
        perf_counter_cell #(
            .CntBit  (CntBit),
            .SatMode (SatMode)
        ) u_cell (
            .clk    (clk),
            .rst_n  (rst_n),
            .en     (en),
            .inc    (inc[i]),
            .clr    (clr),
            .snap   (snap),
            .cnt    (live[i]),
            .shadow (shadow[i]),
            .ovf    (ovf[i])
        );
    end

    // Compare-per-channel mux: a select value with no matching channel
    // (possible when NumCh is not a power of two) falls through to zero.
    always_comb begin
        rd_next = '0;
        for (int i = 0; i < NumCh; i++) begin
            if (sel == SelW'(i)) begin
                rd_next = (rd_src == RD_SRC_SHADOW) ? shadow[i] : live[i];
            end
        end
    end

    // clr deliberately leaves the readout register alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else begin
            rd_data <= rd_next;
        end
    end

endmodule
